// File: rtl/cpu_pkg.sv
// Shared widths, the r0 constant and the ID/EX bundle type for the
// decode-to-execute boundary.
// Configuration macro: IDEX_FORWARD_EN (consumed by id_ex_stage).
package cpu_pkg;

    localparam int DATA_W = 32;
    localparam int ADDR_W = 5;
    localparam int CTRL_W = 8;

    localparam logic [ADDR_W-1:0] REG_ZERO = '0;

    typedef struct packed {
        logic              valid;
        logic [DATA_W-1:0] opA;
        logic [DATA_W-1:0] opB;
        logic [DATA_W-1:0] imm;
        logic [ADDR_W-1:0] rd;
        logic [CTRL_W-1:0] ctrl;
        logic              mem_read;
        logic              reg_write;
    } ex_bundle_t;

    // An empty slot: used for reset, bubbles and flushes.
    localparam ex_bundle_t EX_EMPTY = '0;

    // A producer feeds source src when it writes a real (non-r0) register
    // with the same address.
    function automatic logic producer_match(input logic              we,
                                            input logic [ADDR_W-1:0] rd,
                                            input logic [ADDR_W-1:0] src);
        return we && (rd == src) && (rd != REG_ZERO);
    endfunction

endpackage

// File: rtl/idex_fwd_mux.sv
// Operand resolver for one source register: detects EX/MEM/WB producers
// and, when forwarding is enabled, picks the youngest one.
// match_o bit order: [2]=EX, [1]=MEM, [0]=WB.
module idex_fwd_mux
    import cpu_pkg::*;
#(
    parameter bit FWD_EN = 1'b1
) (
    input  logic [ADDR_W-1:0] src_i,
    input  logic [DATA_W-1:0] rf_data_i,
    input  logic              ex_valid_i,
    input  logic              ex_reg_write_i,
    input  logic [ADDR_W-1:0] ex_rd_i,
    input  logic [DATA_W-1:0] ex_data_i,
    input  logic              mem_reg_write_i,
    input  logic [ADDR_W-1:0] mem_rd_i,
    input  logic [DATA_W-1:0] mem_data_i,
    input  logic              wb_reg_write_i,
    input  logic [ADDR_W-1:0] wb_rd_i,
    input  logic [DATA_W-1:0] wb_data_i,
    output logic [DATA_W-1:0] data_o,
    output logic [2:0]        match_o
);

    // An empty EX slot (bubble/flush/reset) never acts as a producer.
    assign match_o[2] = ex_valid_i && producer_match(ex_reg_write_i, ex_rd_i, src_i);
    assign match_o[1] = producer_match(mem_reg_write_i, mem_rd_i, src_i);
    assign match_o[0] = producer_match(wb_reg_write_i, wb_rd_i, src_i);

    // Youngest producer wins; r0 is forced to zero last so nothing overrides it.
    always_comb begin
        data_o = rf_data_i;
        if (FWD_EN) begin
            if (match_o[2]) begin
                data_o = ex_data_i;
            end else if (match_o[1]) begin
                data_o = mem_data_i;
            end else if (match_o[0]) begin
                data_o = wb_data_i;
            end
        end
        if (src_i == REG_ZERO) begin
            data_o = '0;
        end
    end

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with RAW hazard handling.
// IDEX_FORWARD_EN defined  : EX > MEM > WB forwarding, bubble only on load-use.
// IDEX_FORWARD_EN undefined: no forwarding, any pending producer of a source
//                            stalls decode until it has retired through WB.
module id_ex_stage
    import cpu_pkg::*;
(
    input  logic              elk,
    input  logic              nrst,
    input  logic              id_valid,
    output logic              id_ready,
    input  logic [ADDR_W-1:0] id_rs,
    input  logic [ADDR_W-1:0] id_rt,
    input  logic [ADDR_W-1:0] id_rd,
    input  logic [DATA_W-1:0] id_dataA,
    input  logic [DATA_W-1:0] id_dataB,
    input  logic [DATA_W-1:0] id_imm,
    input  logic [CTRL_W-1:0] id_ctrl,
    input  logic              id_mem_read,
    input  logic              id_reg_write,
    input  logic [DATA_W-1:0] ex_alu_result,
    input  logic              mem_reg_write,
    input  logic [ADDR_W-1:0] mem_rd,
    input  logic [DATA_W-1:0] mem_result,
    input  logic              wb_reg_write,
    input  logic [ADDR_W-1:0] wb_rd,
    input  logic [DATA_W-1:0] wb_data,
    input  logic              ex_ready,
    input  logic              flush,
    output logic              ex_valid,
    output logic [DATA_W-1:0] ex_opA,
    output logic [DATA_W-1:0] ex_opB,
    output logic [DATA_W-1:0] ex_imm,
    output logic [ADDR_W-1:0] ex_rd,
    output logic [CTRL_W-1:0] ex_ctrl,
    output logic              ex_mem_read,
    output logic              ex_reg_write,
    output logic              load_stall
);

`ifdef IDEX_FORWARD_EN
    localparam bit FWD_EN = 1'b1;
`else
    localparam bit FWD_EN = 1'b0;
`endif

    ex_bundle_t        ex_q;
    ex_bundle_t        ex_d;
    logic [DATA_W-1:0] opA_res;
    logic [DATA_W-1:0] opB_res;
    logic [2:0]        match_a;
    logic [2:0]        match_b;
    logic              hazard;
    logic              hold;

    idex_fwd_mux #(.FWD_EN(FWD_EN)) u_fwd_a (
        .src_i           (id_rs),
        .rf_data_i       (id_dataA),
        .ex_valid_i      (ex_q.valid),
        .ex_reg_write_i  (ex_q.reg_write),
        .ex_rd_i         (ex_q.rd),
        .ex_data_i       (ex_alu_result),
        .mem_reg_write_i (mem_reg_write),
        .mem_rd_i        (mem_rd),
        .mem_data_i      (mem_result),
        .wb_reg_write_i  (wb_reg_write),
        .wb_rd_i         (wb_rd),
        .wb_data_i       (wb_data),
        .data_o          (opA_res),
        .match_o         (match_a)
    );

    idex_fwd_mux #(.FWD_EN(FWD_EN)) u_fwd_b (
        .src_i           (id_rt),
        .rf_data_i       (id_dataB),
        .ex_valid_i      (ex_q.valid),
        .ex_reg_write_i  (ex_q.reg_write),
        .ex_rd_i         (ex_q.rd),
        .ex_data_i       (ex_alu_result),
        .mem_reg_write_i (mem_reg_write),
        .mem_rd_i        (mem_rd),
        .mem_data_i      (mem_result),
        .wb_reg_write_i  (wb_reg_write),
        .wb_rd_i         (wb_rd),
        .wb_data_i       (wb_data),
        .data_o          (opB_res),
        .match_o         (match_b)
    );

    // Hazard detection: with forwarding only a load in EX cannot be bypassed
    // (its data is not ready yet); without forwarding every pending producer
    // must retire before the register file read is trusted.
    always_comb begin
        hazard = 1'b0;
        if (FWD_EN) begin
            hazard = id_valid && ex_q.mem_read && (match_a[2] || match_b[2]);
        end else begin
            hazard = id_valid && ((|match_a) || (|match_b));
        end
    end

    assign hold       = ex_q.valid && !ex_ready;
    assign load_stall = hazard;
    // Flush discards the decode instruction, so decode may always advance.
    assign id_ready   = flush || (!hazard && (ex_ready || !ex_q.valid));

    // Next-state selection: flush > hold > bubble > capture > drain to empty.
    always_comb begin
        ex_d = ex_q;
        if (flush) begin
            ex_d = EX_EMPTY;
        end else if (hold) begin
            ex_d = ex_q;
        end else if (id_valid && !hazard) begin
            ex_d.valid     = 1'b1;
            ex_d.opA       = opA_res;
            ex_d.opB       = opB_res;
            ex_d.imm       = id_imm;
            ex_d.rd        = id_rd;
            ex_d.ctrl      = id_ctrl;
            ex_d.mem_read  = id_mem_read;
            ex_d.reg_write = id_reg_write;
        end else begin
            ex_d = EX_EMPTY;
        end
    end

    // Stage register; reset empties the slot immediately.
    always_ff @(posedge elk or negedge nrst) begin
        if (!nrst) begin
            ex_q <= EX_EMPTY;
        end else begin
            ex_q <= ex_d;
        end
    end

    assign ex_valid     = ex_q.valid;
    assign ex_opA       = ex_q.opA;
    assign ex_opB       = ex_q.opB;
    assign ex_imm       = ex_q.imm;
    assign ex_rd        = ex_q.rd;
    assign ex_ctrl      = ex_q.ctrl;
    assign ex_mem_read  = ex_q.mem_read;
    assign ex_reg_write = ex_q.reg_write;

endmodule

// File: doc/id_ex_stage.md
Name: id_ex_stage

Overview:
- Decode-to-execute pipeline register that sits directly downstream of the 32x32 register file.
- Captures the two register-file read operands with their decoded control fields and hands them to the ALU/execute stage.
- Resolves RAW hazards by operand forwarding from the EX, MEM and WB stages, and inserts a one-cycle bubble on load-use hazards.
- Supports flush for branches and jumps, and backpressure from execute.

Parameters:
DATA_W, 32, operand/result width
ADDR_W, 5, register address width (32 architectural registers, r0 hard-wired zero)
CTRL_W, 8, width of opaque ALU/control bundle passed through

Ports:
elk  input  1  clock, rising edge
nrst  input  1  asynchronous active-low reset
id_valid  input  1  decode presents a valid instruction
id_ready  output  1  stage accepts decode instruction this cycle
id_rs  input  ADDR_W  source A register address (also drives register file read port A)
id_rt  input  ADDR_W  source B register address
id_rd  input  ADDR_W  destination register
id_dataA  input  DATA_W  register file read data A
id_dataB  input  DATA_W  register file read data B
id_imm  input  DATA_W  sign-extended immediate
id_ctrl  input  CTRL_W  ALU op / misc control
id_mem_read  input  1  instruction is a load
id_reg_write  input  1  instruction writes rd
ex_alu_result  input  DATA_W  combinational ALU result of instruction currently held in this stage
mem_reg_write, mem_rd, mem_result  input  1/ADDR_W/DATA_W  MEM-stage producer
wb_reg_write, wb_rd, wb_data  input  1/ADDR_W/DATA_W  WB producer (same bus that writes the register file)
ex_ready  input  1  execute accepts held instruction
flush  input  1  kill instruction in decode and in this stage
ex_valid  output  1  held instruction valid
ex_opA, ex_opB, ex_imm  output  DATA_W  resolved operands, immediate
ex_rd  output  ADDR_W
ex_ctrl  output  CTRL_W
ex_mem_read, ex_reg_write  output  1
load_stall  output  1  bubble being inserted this cycle

Behaviour:
- Reset (nrst=0, asynchronous): every ex_* output goes to 0 (ex_valid=0). load_stall=0. id_ready follows the combinational rules with ex_valid=0.
- Producer match: a producer matches source s when reg_write=1, rd==s and rd!=0. A matching EX producer also requires ex_valid=1.
- Forward priority per operand: EX (ex_alu_result) > MEM > WB > register file.
- Source r0: always resolves to 0, regardless of register file data or any producer.
- Load-use hazard: asserted when ex_valid, ex_mem_read and ex_reg_write are all 1, and ex_rd!=0 matches id_rs or id_rt, with id_valid=1.
- On a load-use hazard:
  - load_stall=1 and id_ready=0.
  - If ex_ready=1, the next cycle holds a bubble (ex_valid=0, all ex_* fields zeroed).
  - The hazard persists at most 1 cycle because the load advances.
- id_ready = !load_stall && (ex_ready || !ex_valid).
- Capture: when id_valid && id_ready, all fields are captured on the rising edge of elk. Latency decode→execute is 1 cycle.
- Hold: if ex_valid && !ex_ready, outputs are held unchanged.
- Flush:
  - Forces ex_valid=0 next edge and clears all fields.
  - id_ready=1, so the decode instruction is discarded.
  - Flush beats stall and hold.
- Bubble and flushed entries never match as producers.
- Fields are registered; there is no combinational path from id_* to ex_*.

Optional Feature:
- Macro: IDEX_FORWARD_EN.
- Defined: forwarding as above.
- Undefined:
  - No forwarding muxes. Operands come from the register file (r0 still forced to 0).
  - Any EX, MEM or WB producer match on a used source stalls: load_stall=1, id_ready=0, bubble inserted, until no match remains.
  - Back-to-back dependent ALU ops therefore cost 3 bubbles.

Decomposition:
- Shared package (cpu_pkg): DATA_W, ADDR_W, CTRL_W, REG_ZERO constant, typedef ex_bundle_t (valid, opA, opB, imm, rd, ctrl, mem_read, reg_write).
- One sub-module, idex_fwd_mux, instantiated twice (operand A and operand B). Inputs: source address plus the three producers. Outputs: resolved data and a match vector used for hazard detection.

Test Plan:
- Reset: nrst low mid-stream with ex_valid=1 → all ex_* go to 0 immediately. After release, id_valid=1, id_rs=3 with dataA=0x11 → ex_opA=0x11 one edge later.
- Forward priority: rs=5; EX, MEM and WB all write r5 with 0xAAAA/0xBBBB/0xCCCC → ex_opA=0xAAAA. EX drops → 0xBBBB. MEM drops → 0xCCCC.
- r0 guard: rs=0, dataA=0xDEAD, EX writes rd=0 with 0x1234 → ex_opA=0.
- Load-use: held lw r8, next decode add r9,r8,r2 → load_stall=1, id_ready=0 for 1 cycle, then a bubble (ex_valid=0). Next edge the add is captured with opA=mem_result.
- Flush during stall and hold: ex_ready=0, load-use active, flush=1 → next edge ex_valid=0, id_ready=1, decode instruction discarded.
- Without IDEX_FORWARD_EN: add r4 then sub using r4 → exactly 3 bubble cycles, after which the sub captures the register file value.
